serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/serial_adder_full_adder.sv | 44 ++++
 rtl/serial_adder.sv | 116 +++++++++++
 tb/tb_serial_adder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and counter sizing.
package serial_adder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ADD  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Counter only has to reach WIDTH-1, so ceil(log2(WIDTH)) bits are enough.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder built from two half adders and an OR for the carry.
// Purely combinational, no latency, no flow control.
module HalfAdder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic s0;
  logic c0;
  logic c1;

  HalfAdder u_ha0 (
    .a_i (a_i),
    .b_i (b_i),
    .s_o (s0),
    .c_o (c0)
  );

  HalfAdder u_ha1 (
    .a_i (s0),
    .b_i (c_i),
    .s_o (s_o),
    .c_o (c1)
  );

  // The two half-adder carries can never both be set, so OR gives majority.
  assign c_o = c0 | c1;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first, one full-adder bit per clock.
// Latency: start at edge 0 -> done high the cycle after edge WIDTH; start ignored unless idle.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s;
  logic             fa_c;

  full_adder u_fa (
    .a_i (a_sr_q[0]),
    .b_i (b_sr_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ADD;
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          res_d   = '0;
        end
      end

      ST_ADD: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_c;
        // Publish the result on the final bit so sum/cout only move on entry to DONE.
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          cout_d  = fa_c;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == ST_ADD);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus random ops against an arithmetic model.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks = 0;
  int errors = 0;

  // Result the DUT should be holding between operations.
  logic [W-1:0] hold_sum;
  logic         hold_cout;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Called at a negedge with the DUT idle. Cycle n is the n-th negedge after the start edge.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic ocin,
                       input int ign_cyc, input int rst_cyc,
                       output logic [W-1:0] osum, output logic ocout, output int done_cyc,
                       output int busy_cnt, output int hold_err, output int excl_err,
                       output logic r_busy, output logic [W-1:0] r_sum, output logic r_cout);
    a = oa; b = ob; cin = ocin; start = 1'b1;
    done_cyc = 0; busy_cnt = 0; hold_err = 0; excl_err = 0;
    osum = '0; ocout = 1'b0; r_busy = 1'b1; r_sum = '1; r_cout = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (busy && done) excl_err++;
      if (busy) busy_cnt++;
      if (rst_cyc != 0 && cyc == rst_cyc + 1) begin
        r_busy = busy; r_sum = sum; r_cout = cout;
      end
      if (busy && (rst_cyc == 0 || cyc <= rst_cyc) && (sum !== hold_sum || cout !== hold_cout))
        hold_err++;
      if (done) begin
        done_cyc = cyc; osum = sum; ocout = cout;
        break;
      end
      start = (cyc == ign_cyc);
      if (cyc == ign_cyc) begin
        a = ~oa; b = W'($urandom); cin = ~ocin;
      end
      rst = (rst_cyc != 0 && cyc == rst_cyc);
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 8'hC3; b = 8'h3C; cin = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_flags busy=%b done=%b exp 0 0", busy, done);
    end
    checks++;
    if (sum !== 8'h00 || cout !== 1'b0) begin
      errors++; $display("FAIL reset_result sum=%h cout=%b exp 00 0", sum, cout);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_priority busy=%b exp 0", busy);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_idle busy=%b done=%b exp 0 0", busy, done);
    end
    hold_sum = '0; hold_cout = 1'b0;
  endtask

  task automatic test_zero();
    logic [W-1:0] s, rs; logic c, rb, rc; int dc, bc, he, ee;
    do_op(8'h00, 8'h00, 1'b0, 0, 0, s, c, dc, bc, he, ee, rb, rs, rc);
    checks++;
    if (s !== 8'h00 || c !== 1'b0) begin
      errors++; $display("FAIL zero_result sum=%h cout=%b exp 00 0", s, c);
    end
    checks++;
    if (dc !== 9) begin
      errors++; $display("FAIL zero_latency done_cycle=%0d exp 9", dc);
    end
    hold_sum = 8'h00; hold_cout = 1'b0;
  endtask

  task automatic test_carry_chain();
    logic [W-1:0] s, rs; logic c, rb, rc; int dc, bc, he, ee;
    do_op(8'hFF, 8'h01, 1'b0, 0, 0, s, c, dc, bc, he, ee, rb, rs, rc);
    checks++;
    if (s !== 8'h00 || c !== 1'b1) begin
      errors++; $display("FAIL carry_result sum=%h cout=%b exp 00 1", s, c);
    end
    checks++;
    if (bc !== 8) begin
      errors++; $display("FAIL carry_busy_cycles busy=%0d exp 8", bc);
    end
    checks++;
    if (ee !== 0) begin
      errors++; $display("FAIL carry_exclusive overlaps=%0d exp 0", ee);
    end
    hold_sum = 8'h00; hold_cout = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] s, rs; logic c, rb, rc; int dc, bc, he, ee;
    do_op(8'h5A, 8'hA5, 1'b1, 0, 0, s, c, dc, bc, he, ee, rb, rs, rc);
    checks++;
    if (s !== 8'h00 || c !== 1'b1) begin
      errors++; $display("FAIL b2b_first sum=%h cout=%b exp 00 1", s, c);
    end
    hold_sum = 8'h00; hold_cout = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_done_pulse done=%b busy=%b exp 0 0", done, busy);
    end
    do_op(8'h5A, 8'hA5, 1'b0, 0, 0, s, c, dc, bc, he, ee, rb, rs, rc);
    checks++;
    if (s !== 8'hFF || c !== 1'b0) begin
      errors++; $display("FAIL b2b_second sum=%h cout=%b exp ff 0", s, c);
    end
    checks++;
    if (dc !== 9) begin
      errors++; $display("FAIL b2b_latency done_cycle=%0d exp 9", dc);
    end
    checks++;
    if (he !== 0) begin
      errors++; $display("FAIL b2b_hold changes=%0d exp 0", he);
    end
    hold_sum = 8'hFF; hold_cout = 1'b0;
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] s, rs, x, y; logic c, rb, rc, ci; logic [W:0] e; int dc, bc, he, ee, extra;
    x = W'($urandom); y = W'($urandom); ci = 1'($urandom);
    e = model(x, y, ci);
    @(negedge clk);
    do_op(x, y, ci, 3, 0, s, c, dc, bc, he, ee, rb, rs, rc);
    checks++;
    if (s !== e[W-1:0] || c !== e[W]) begin
      errors++; $display("FAIL ignore_result sum=%h cout=%b exp %h %b", s, c, e[W-1:0], e[W]);
    end
    checks++;
    if (dc !== 9) begin
      errors++; $display("FAIL ignore_latency done_cycle=%0d exp 9", dc);
    end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy || done) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++; $display("FAIL ignore_not_queued active_cycles=%0d exp 0", extra);
    end
    hold_sum = e[W-1:0]; hold_cout = e[W];
  endtask

  task automatic test_max();
    logic [W-1:0] s, rs; logic c, rb, rc; int dc, bc, he, ee;
    do_op(8'hFF, 8'hFF, 1'b1, 0, 0, s, c, dc, bc, he, ee, rb, rs, rc);
    checks++;
    if (s !== 8'hFF || c !== 1'b1) begin
      errors++; $display("FAIL max_result sum=%h cout=%b exp ff 1", s, c);
    end
    hold_sum = 8'hFF; hold_cout = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] s, rs; logic c, rb, rc; int dc, bc, he, ee;
    do_op(8'h3C, 8'h4B, 1'b1, 0, 4, s, c, dc, bc, he, ee, rb, rs, rc);
    checks++;
    if (rb !== 1'b0 || rs !== 8'h00 || rc !== 1'b0) begin
      errors++; $display("FAIL midrst_state busy=%b sum=%h cout=%b exp 0 00 0", rb, rs, rc);
    end
    checks++;
    if (dc !== 0) begin
      errors++; $display("FAIL midrst_no_done done_cycle=%0d exp 0", dc);
    end
    checks++;
    if (bc !== 4) begin
      errors++; $display("FAIL midrst_busy_cycles busy=%0d exp 4", bc);
    end
    hold_sum = 8'h00; hold_cout = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] s, rs, x, y; logic c, rb, rc, ci; logic [W:0] e; int dc, bc, he, ee;
    for (int n = 0; n < 1000; n++) begin
      x = W'($urandom); y = W'($urandom); ci = 1'($urandom);
      e = model(x, y, ci);
      repeat ($urandom_range(1, 3)) @(negedge clk);
      do_op(x, y, ci, 0, 0, s, c, dc, bc, he, ee, rb, rs, rc);
      checks++;
      if (s !== e[W-1:0] || c !== e[W]) begin
        errors++;
        $display("FAIL rand_result a=%h b=%h cin=%b sum=%h cout=%b exp %h %b",
                 x, y, ci, s, c, e[W-1:0], e[W]);
      end
      checks++;
      if (dc !== 9 || he !== 0 || ee !== 0) begin
        errors++;
        $display("FAIL rand_timing done_cycle=%0d hold_changes=%0d overlaps=%0d exp 9 0 0",
                 dc, he, ee);
      end
      hold_sum = e[W-1:0]; hold_cout = e[W];
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    @(negedge clk);
    test_carry_chain();
    @(negedge clk);
    test_back_to_back();
    test_ignore_start();
    test_max();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout sim_time=%0t limit=1000000", $time);
    $fatal(1, "timeout");
  end

endmodule
